// File: rtl/mux_scan_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_serializer_pkg
//  Description : Shared widths, state encoding and select-step helper for the
//                mux-driven parallel-to-serial stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_scan_serializer_pkg;

    localparam int c_WORD_W = 16;
    localparam int c_SEL_W  = 4;
    localparam int c_DIV_W  = 8;

    typedef logic [0:0] state_t;

    localparam state_t c_ST_IDLE  = 1'b0;
    localparam state_t c_ST_SHIFT = 1'b1;

    // Advance the mux select one position in the configured direction.
    function automatic logic [c_SEL_W-1:0] sel_step(
        input logic [c_SEL_W-1:0] sel_cur,
        input logic               msb_first
    );
        if (msb_first) begin
            sel_step = sel_cur - 4'd1;
        end else begin
            sel_step = sel_cur + 4'd1;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_scan_serializer_mux16x1.sv
`default_nettype none
// ============================================================================
//  Module      : mux16x1
//  Description : 16:1 single-bit multiplexer cell, y = d[s].
//  Revision    : 1.0 - initial release
// ============================================================================
module mux16x1 (
    input  logic [15:0] d,
    input  logic [3:0]  s,
    output logic        y
);

    assign y = d[s];

endmodule
`default_nettype wire

// File: rtl/mux_scan_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_serializer
//  Description : Captures a 16-bit word over valid/ready, then steps the
//                select of a mux16x1 so the word leaves one bit at a time,
//                each bit held for HOLD_CYCLES clocks, with valid/last framing.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_serializer
    import mux_scan_serializer_pkg::*;
#(
    parameter int unsigned MSB_FIRST   = 1,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        abort,
    output logic [3:0]  sel,
    output logic        ser_out,
    output logic        ser_valid,
    output logic        ser_last,
    output logic        busy
);

    // Elaboration-time legality checks on the configuration.
    if ((HOLD_CYCLES < 1) || (HOLD_CYCLES > 256)) begin : g_hold_range_err
        $error("mux_scan_serializer: HOLD_CYCLES must be within 1..256");
    end
    if (MSB_FIRST > 1) begin : g_msb_first_err
        $error("mux_scan_serializer: MSB_FIRST must be 0 or 1");
    end

    localparam logic             c_MSB_FIRST = (MSB_FIRST != 0);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(HOLD_CYCLES - 1);
    localparam logic [c_SEL_W-1:0] c_SEL_FIRST = c_MSB_FIRST ? 4'd15 : 4'd0;
    localparam logic [c_SEL_W-1:0] c_SEL_LAST  = c_MSB_FIRST ? 4'd0  : 4'd15;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_WORD_W-1:0] r_data;
    logic [c_SEL_W-1:0]  r_sel;
    logic [c_DIV_W-1:0]  r_div;

    logic w_last_bit;
    logic w_div_end;
    logic w_word_end;
    logic w_accept;
    logic w_mux_y;

    // Final bit of the word, and the final clock of that bit.
    assign w_last_bit = (r_sel == c_SEL_LAST);
    assign w_div_end  = (r_div == c_DIV_LAST);
    assign w_word_end = (r_state == c_ST_SHIFT) && w_last_bit && w_div_end;
    assign w_accept   = in_valid && in_ready;

    // The serial bit comes straight from the registered word and select.
    mux16x1 u_mux (
        .d (r_data),
        .s (r_sel),
        .y (w_mux_y)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort overrides everything, a word end with a new
    // word waiting stays in SHIFT for a gapless stream.
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        w_state_nxt = c_ST_SHIFT;
                    end
                end
                c_ST_SHIFT: begin
                    if (w_word_end) begin
                        w_state_nxt = w_accept ? c_ST_SHIFT : c_ST_IDLE;
                    end
                end
                default: w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // Word, select and bit-period counters; select parks at 0 when a word
    // finishes without a successor so it never wraps within a word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_sel  <= '0;
            r_div  <= '0;
        end else if (abort) begin
            r_sel <= '0;
            r_div <= '0;
        end else if (w_accept) begin
            r_data <= in_data;
            r_sel  <= c_SEL_FIRST;
            r_div  <= '0;
        end else if (r_state == c_ST_SHIFT) begin
            if (w_div_end) begin
                r_div <= '0;
                r_sel <= w_last_bit ? '0 : sel_step(r_sel, c_MSB_FIRST);
            end else begin
                r_div <= r_div + 8'd1;
            end
        end
    end

    // Outputs; serial data and framing are gated off outside SHIFT.
    always_comb begin
        in_ready  = 1'b0;
        ser_valid = 1'b0;
        ser_out   = 1'b0;
        ser_last  = 1'b0;
        busy      = 1'b0;
        sel       = r_sel;
        if (!abort) begin
            in_ready = (r_state == c_ST_IDLE) || w_word_end;
        end
        if (r_state == c_ST_SHIFT) begin
            ser_valid = 1'b1;
            busy      = 1'b1;
            ser_out   = w_mux_y;
            ser_last  = w_last_bit;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_scan_serializer
//  Description : Directed self-checking bench; one instance MSB-first with
//                single-clock bits, one LSB-first holding each bit 3 clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_serializer;

    logic clk;
    logic clk_en;
    logic rst_n;

    logic [15:0] a_in_data, b_in_data;
    logic        a_in_valid, b_in_valid;
    logic        a_abort, b_abort;
    logic        a_in_ready, b_in_ready;
    logic [3:0]  a_sel, b_sel;
    logic        a_ser_out, b_ser_out;
    logic        a_ser_valid, b_ser_valid;
    logic        a_ser_last, b_ser_last;
    logic        a_busy, b_busy;

    int checks;
    int errors;

    mux_scan_serializer #(.MSB_FIRST(1), .HOLD_CYCLES(1)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (a_in_data),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .abort     (a_abort),
        .sel       (a_sel),
        .ser_out   (a_ser_out),
        .ser_valid (a_ser_valid),
        .ser_last  (a_ser_last),
        .busy      (a_busy)
    );

    mux_scan_serializer #(.MSB_FIRST(0), .HOLD_CYCLES(3)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .abort     (b_abort),
        .sel       (b_sel),
        .ser_out   (b_ser_out),
        .ser_valid (b_ser_valid),
        .ser_last  (b_ser_last),
        .busy      (b_busy)
    );

    // Gateable clock so reset can be applied with the clock stopped.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a_idle(input string tag);
        chk({tag, "_valid"}, {15'd0, a_ser_valid}, 16'd0);
        chk({tag, "_busy"},  {15'd0, a_busy},      16'd0);
        chk({tag, "_out"},   {15'd0, a_ser_out},   16'd0);
        chk({tag, "_last"},  {15'd0, a_ser_last},  16'd0);
    endtask

    initial begin
        logic [15:0] word;
        logic        exp_bit;
        checks     = 0;
        errors     = 0;
        clk        = 1'b0;
        clk_en     = 1'b1;
        rst_n      = 1'b0;
        a_in_data  = 16'h0;
        a_in_valid = 1'b0;
        a_abort    = 1'b0;
        b_in_data  = 16'h0;
        b_in_valid = 1'b0;
        b_abort    = 1'b0;

        // Reset state with the clock running.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel", {12'd0, a_sel}, 16'd0);
        chk("rst_ready", {15'd0, a_in_ready}, 16'd1);
        chk_a_idle("rst");
        chk("rst_b_ready", {15'd0, b_in_ready}, 16'd1);
        rst_n = 1'b1;
        tick();

        // Word 0xA5C3 MSB first, one clock per bit.
        word       = 16'hA5C3;
        a_in_data  = word;
        a_in_valid = 1'b1;
        chk("t2_ready_idle", {15'd0, a_in_ready}, 16'd1);
        tick();
        a_in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_bit = word[15-i];
            chk($sformatf("t2_out%0d", i),   {15'd0, a_ser_out},   {15'd0, exp_bit});
            chk($sformatf("t2_sel%0d", i),   {12'd0, a_sel},       16'(15 - i));
            chk($sformatf("t2_valid%0d", i), {15'd0, a_ser_valid}, 16'd1);
            chk($sformatf("t2_last%0d", i),  {15'd0, a_ser_last},  (i == 15) ? 16'd1 : 16'd0);
            chk($sformatf("t2_ready%0d", i), {15'd0, a_in_ready},  (i == 15) ? 16'd1 : 16'd0);
            tick();
        end
        chk_a_idle("t2_end");
        chk("t2_end_ready", {15'd0, a_in_ready}, 16'd1);

        // Back-to-back 0xFFFF then 0x0001, in_valid held high.
        a_in_data  = 16'hFFFF;
        a_in_valid = 1'b1;
        tick();
        a_in_data = 16'h0001;
        for (int i = 0; i < 32; i++) begin
            if (i == 16) a_in_valid = 1'b0;
            exp_bit = (i < 16) || (i == 31);
            chk($sformatf("t3_out%0d", i),   {15'd0, a_ser_out},   {15'd0, exp_bit});
            chk($sformatf("t3_valid%0d", i), {15'd0, a_ser_valid}, 16'd1);
            chk($sformatf("t3_last%0d", i),  {15'd0, a_ser_last},
                ((i == 15) || (i == 31)) ? 16'd1 : 16'd0);
            tick();
        end
        chk_a_idle("t3_end");

        // Abort while sel is 7.
        a_in_data  = 16'hA5C3;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        repeat (8) tick();
        chk("t5_sel7", {12'd0, a_sel}, 16'd7);
        a_abort = 1'b1;
        #1;
        chk("t5_ready_abort", {15'd0, a_in_ready}, 16'd0);
        tick();
        chk("t5_sel0", {12'd0, a_sel}, 16'd0);
        chk_a_idle("t5_post");
        a_abort = 1'b0;
        #1;
        chk("t5_ready_after", {15'd0, a_in_ready}, 16'd1);
        a_in_data  = 16'h8000;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        chk("t5_new_sel", {12'd0, a_sel}, 16'd15);
        chk("t5_new_out", {15'd0, a_ser_out}, 16'd1);
        chk("t5_new_valid", {15'd0, a_ser_valid}, 16'd1);
        tick();
        chk("t5_new_sel14", {12'd0, a_sel}, 16'd14);
        chk("t5_new_out14", {15'd0, a_ser_out}, 16'd0);
        repeat (15) tick();
        chk_a_idle("t5_end");

        // in_valid and abort together in IDLE: no handshake.
        a_in_data  = 16'hFFFF;
        a_in_valid = 1'b1;
        a_abort    = 1'b1;
        #1;
        chk("t6_ready", {15'd0, a_in_ready}, 16'd0);
        tick();
        chk_a_idle("t6_a");
        tick();
        chk_a_idle("t6_b");
        a_in_valid = 1'b0;
        a_abort    = 1'b0;
        tick();
        chk_a_idle("t6_c");

        // Reset asserted mid-word with the clock stopped.
        a_in_data  = 16'hFFFF;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        repeat (3) tick();
        chk("t1_busy_before", {15'd0, a_busy}, 16'd1);
        clk_en = 1'b0;
        #10;
        rst_n = 1'b0;
        #1;
        chk("t1_sel", {12'd0, a_sel}, 16'd0);
        chk("t1_ready", {15'd0, a_in_ready}, 16'd1);
        chk_a_idle("t1_async");
        #3;
        rst_n = 1'b1;
        #1;
        clk_en = 1'b1;
        tick();
        chk_a_idle("t1_after");
        a_in_data  = 16'h8000;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        chk("t1_fresh_sel", {12'd0, a_sel}, 16'd15);
        chk("t1_fresh_out", {15'd0, a_ser_out}, 16'd1);
        repeat (16) tick();
        chk_a_idle("t1_fresh_end");

        // LSB first, 3 clocks per bit, word 0x0001.
        b_in_data  = 16'h0001;
        b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        for (int i = 0; i < 48; i++) begin
            chk($sformatf("t4_out%0d", i),   {15'd0, b_ser_out},   (i < 3) ? 16'd1 : 16'd0);
            chk($sformatf("t4_sel%0d", i),   {12'd0, b_sel},       16'(i / 3));
            chk($sformatf("t4_valid%0d", i), {15'd0, b_ser_valid}, 16'd1);
            chk($sformatf("t4_last%0d", i),  {15'd0, b_ser_last},  (i >= 45) ? 16'd1 : 16'd0);
            chk($sformatf("t4_ready%0d", i), {15'd0, b_in_ready},  (i == 47) ? 16'd1 : 16'd0);
            tick();
        end
        chk("t4_end_valid", {15'd0, b_ser_valid}, 16'd0);
        chk("t4_end_busy",  {15'd0, b_busy},      16'd0);
        chk("t4_end_out",   {15'd0, b_ser_out},   16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
